// File: rtl/progmem_pkg.sv
// Shared types and the round-robin pick helper for the program-memory arbiter.
package progmem_pkg;

    localparam int unsigned MAX_CORES = 16;

    // Result of a round-robin search: whether anyone was eligible, and who.
    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First set bit of elig at index >= ptr, wrapping modulo n_cores.
    // Walks offsets high-to-low so the smallest offset wins the last write.
    function automatic rr_pick_t rr_pick(input logic [15:0] elig,
                                         input logic [3:0]  ptr,
                                         input logic [4:0]  n_cores);
        rr_pick_t   pick;
        logic [4:0] idx;
        pick = '0;
        for (int k = MAX_CORES - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + 5'(k);
            if (idx >= n_cores) begin
                idx = idx - n_cores;
            end else begin
                idx = idx;
            end
            if ((5'(k) < n_cores) && elig[idx[3:0]]) begin
                pick.found = 1'b1;
                pick.idx   = idx[3:0];
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/progmem_lat_pipe.sv
// Fixed-depth valid/id shift pipeline that tracks reads in flight to memory.
module progmem_lat_pipe #(
    parameter int DEPTH = 2,
    parameter int ID_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id
);

    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [DEPTH-1:0][ID_W-1:0] id_q, id_d;

    // Shift every stage one step toward the output, loading stage 0 from the input.
    always_comb begin
        valid_d    = valid_q;
        id_d       = id_q;
        valid_d[0] = in_valid;
        id_d[0]    = in_id;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            id_d[i]    = id_q[i-1];
        end
    end

    // Pipeline registers; reset drops every read that is still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/progmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency program memory among N cores.
`ifndef INST_W
`define INST_W 32
`endif
`ifndef INST_ADDR_W
`define INST_ADDR_W 16
`endif

module progmem_arbiter
    import progmem_pkg::*;
#(
    parameter int N_CORES     = 4,
    parameter int INST_W      = `INST_W,
    parameter int INST_ADDR_W = `INST_ADDR_W,
    parameter int MEM_LAT     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [N_CORES-1:0]             core_req,
    input  logic [N_CORES*INST_ADDR_W-1:0] core_addr,
    output logic [N_CORES-1:0]             core_rsp_valid,
    output logic [INST_W-1:0]              core_rsp_data,
    output logic                           mem_rd,
    output logic [INST_ADDR_W-1:0]         mem_addr,
    input  logic [INST_W-1:0]              mem_data
);

    localparam int ID_W = $clog2(N_CORES);

    logic [ID_W-1:0]        rr_q, rr_d;
    logic [N_CORES-1:0]     busy_q, busy_d;
    logic [15:0]            elig_s;
    rr_pick_t               pick_s;
    logic                   grant_s;
    logic [ID_W-1:0]        grant_id_s;
    logic                   out_valid_s;
    logic [ID_W-1:0]        out_id_s;
    logic [INST_ADDR_W-1:0] addr_arr_s [N_CORES];

    // Unpack the flat per-core address bus.
    for (genvar g = 0; g < N_CORES; g++) begin : g_addr
        assign addr_arr_s[g] = core_addr[g*INST_ADDR_W +: INST_ADDR_W];
    end

    // Eligible cores are requesting and have no read outstanding.
    always_comb begin
        elig_s                = 16'h0000;
        elig_s[N_CORES-1:0]   = core_req & ~busy_q;
    end

    assign pick_s     = rr_pick(elig_s, 4'(rr_q), 5'(N_CORES));
    assign grant_s    = en & ~rst & pick_s.found;
    assign grant_id_s = pick_s.idx[ID_W-1:0];

    // Memory strobe follows the grant decision within the same cycle.
    always_comb begin
        mem_rd   = grant_s;
        mem_addr = '0;
        if (grant_s) begin
            mem_addr = addr_arr_s[grant_id_s];
        end else begin
            mem_addr = '0;
        end
    end

    // Next pointer and in-flight marks: retire the returning core, mark the granted one.
    always_comb begin
        rr_d   = rr_q;
        busy_d = busy_q;
        if (out_valid_s) begin
            busy_d[out_id_s] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (grant_s) begin
            busy_d[grant_id_s] = 1'b1;
            if (grant_id_s == ID_W'(N_CORES - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = grant_id_s + ID_W'(1);
            end
        end else begin
            rr_d = rr_q;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q   <= '0;
            busy_q <= '0;
        end else begin
            rr_q   <= rr_d;
            busy_q <= busy_d;
        end
    end

    progmem_lat_pipe #(
        .DEPTH (MEM_LAT),
        .ID_W  (ID_W)
    ) u_lat_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (grant_s),
        .in_id     (grant_id_s),
        .out_valid (out_valid_s),
        .out_id    (out_id_s)
    );

    // Steer the returning instruction to its owner; the data bus is zero when idle.
    always_comb begin
        core_rsp_valid = '0;
        core_rsp_data  = '0;
        for (int i = 0; i < N_CORES; i++) begin
            core_rsp_valid[i] = out_valid_s && (out_id_s == ID_W'(i));
        end
        if (out_valid_s) begin
            core_rsp_data = mem_data;
        end else begin
            core_rsp_data = '0;
        end
    end

endmodule
